// File: rtl/aes32_dec_out_collect.sv
// Collects 32-bit AES decryptor output words into 128-bit blocks and queues them in a FWFT FIFO.
// Optional sticky overflow flag: define AES32_COLLECT_OVF_EN.
module aes32_dec_out_collect #(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         DONE_IN,
  input  logic [31:0]  DIN,
  input  logic         CLR,
  output logic [127:0] DOUT,
  output logic         VALID,
  input  logic         READY,
  output logic [4:0]   LEVEL,
  output logic         OVF
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  logic [1:0]     widx;
  logic [95:0]    asm_p0;
  logic [127:0]   mem [0:DEPTH-1];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [4:0]     level;
  logic           full;
  logic           push_req;
  logic           push;
  logic           pop;

  assign full     = (level == DEPTH_L);
  assign push_req = DONE_IN && (widx == 2'd3) && !CLR;
  assign pop      = (level != 5'd0) && READY && !CLR;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);

  // Stage p0: word assembly; a gap in DONE_IN abandons any partial block.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      widx   <= 2'd0;
      asm_p0 <= '0;
    end else if (CLR) begin
      widx <= 2'd0;
    end else if (DONE_IN) begin
      case (widx)
        2'd0:    asm_p0[95:64] <= DIN;
        2'd1:    asm_p0[63:32] <= DIN;
        2'd2:    asm_p0[31:0]  <= DIN;
        default: ;
      endcase
      widx <= widx + 2'd1;
    end else begin
      widx <= 2'd0;
    end
  end

  // Stage p1: block storage; word 3 bypasses the assembly register.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {asm_p0, DIN};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else if (CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: ;
      endcase
    end
  end

  assign VALID = (level != 5'd0);
  assign LEVEL = level;
  // Storage is not reset, so the head is masked whenever the FIFO is empty.
  assign DOUT  = VALID ? mem[rd_ptr] : '0;

`ifdef AES32_COLLECT_OVF_EN
  logic ovf_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                       ovf_q <= 1'b0;
    else if (CLR)                     ovf_q <= 1'b0;
    else if (push_req && full && !pop) ovf_q <= 1'b1;
  end

  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

endmodule

// File: doc/aes32_dec_out_collect.md
AES32_DEC_OUT_COLLECT -- requirements
Module: aes32_dec_out_collect

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO depth in 128-bit blocks; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all logic on the rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port DONE_IN, input, 1 bit: decryptor DONE; DIN is a valid word on every cycle it is high.
REQ-005 SHALL have port DIN, input, 32 bits: decryptor plaintext word.
REQ-006 SHALL have port CLR, input, 1 bit: synchronous flush.
REQ-007 SHALL have port DOUT, output, 128 bits: head-of-FIFO plaintext block.
REQ-008 SHALL have port VALID, output, 1 bit: DOUT holds a block.
REQ-009 SHALL have port READY, input, 1 bit: consumer accepts the block.
REQ-010 SHALL have port LEVEL, output, 5 bits: number of blocks stored, 0..DEPTH.
REQ-011 SHALL have port OVF, output, 1 bit: sticky overflow flag.

Function
REQ-012 SHALL capture DIN on every rising edge with DONE_IN=1, using a 2-bit word index widx.
- widx=0 -> bits [127:96]; 1 -> [95:64]; 2 -> [63:32]; 3 -> [31:0].
REQ-013 SHALL increment widx on each captured word, wrapping 3->0.
- A standard 8-cycle DONE burst yields two blocks.
REQ-014 SHALL write the assembled block into the FIFO on the edge that captures word 3, with word 3 taken directly from DIN (no extra cycle).
REQ-015 SHALL, when DONE_IN falls with widx!=0, discard the partial block, return widx to 0, and write nothing.
REQ-016 SHALL implement the FIFO as first-word-fall-through.
- DOUT = head entry combinationally.
- VALID = (LEVEL!=0).
- Latency: block written at edge N -> VALID=1 and DOUT correct in cycle N+1 when the FIFO was empty.
REQ-017 SHALL pop on an edge with VALID=1 and READY=1; READY with VALID=0 has no effect.
REQ-018 SHALL hold DOUT stable while VALID=1 and READY=0.
REQ-019 SHALL, on a simultaneous push and pop, leave LEVEL unchanged and keep order; when full, the push SHALL be accepted because the pop frees the slot.
REQ-020 SHALL, on a push with LEVEL=DEPTH and no pop, drop the new block and leave the contents unchanged.
REQ-021 SHALL wrap read/write pointers modulo DEPTH, with full/empty derived from LEVEL.
REQ-022 SHALL, on CLR=1, empty the FIFO, set widx=0, clear OVF, and ignore DONE_IN/READY that cycle; CLR takes priority over all other events.

Reset
REQ-023 SHALL, while RST_N=0, asynchronously force:
- VALID=0, LEVEL=0, OVF=0, widx=0;
- pointers=0, assembly register=0, DOUT=0.
REQ-024 SHALL, on reset asserted mid-burst or mid-block, discard all partial and stored data; capture resumes on the first DONE_IN=1 edge after release, as word 0.
REQ-025 SHALL NOT require storage RAM contents to be reset; DOUT SHALL read 0 whenever VALID=0.

Configuration
REQ-026 SHALL support macro AES32_COLLECT_OVF_EN.
- Defined: OVF set on any drop per REQ-020, held until CLR or reset.
- Undefined: OVF tied to 0 and no overflow logic synthesized; drop behaviour per REQ-020 unchanged.

Verification
REQ-027 SHALL cover: 8-cycle DONE_IN burst with DIN=0x00000001..0x00000008, READY=1 -> two blocks: DOUT=0x00000001_00000002_00000003_00000004 one cycle after word 4, then 0x00000005_..._00000008 one cycle after word 8; LEVEL max 1.
REQ-028 SHALL cover: READY=0, DEPTH=4, three 8-word bursts -> LEVEL=4, fifth and sixth blocks dropped, OVF=1 (macro defined) or 0 (undefined); then READY=1 yields the first four blocks in order.
REQ-029 SHALL cover: DONE_IN high 6 cycles (words A..F) then low, then an 8-word burst -> one block A..D, E/F discarded, the next two blocks start at the new burst's first word.
REQ-030 SHALL cover: FIFO full with READY=1 on the same edge as a word-3 capture -> LEVEL stays 4, no drop, OVF=0, new block last out.
REQ-031 SHALL cover: RST_N pulsed low asynchronously between edges after word 2 with LEVEL=2 -> VALID=0, LEVEL=0, DOUT=0 immediately; the next burst assembles from word 0.
REQ-032 SHALL cover: CLR asserted with LEVEL=3, widx=2, OVF=1, READY=1 -> next cycle LEVEL=0, VALID=0, OVF=0, no pop counted.
